// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch-stage PC controller:
// controller states and next-PC mux select codes.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [1:0] SEL_SEQ  = 2'd0;
    localparam logic [1:0] SEL_BR   = 2'd1;
    localparam logic [1:0] SEL_JMP  = 2'd2;
    localparam logic [1:0] SEL_TRAP = 2'd3;

endpackage

// File: rtl/fetch_sel_prio.sv
// Next-PC mux select: priority trap > jump > branch > sequential.
// Purely combinational.
module fetch_sel_prio
    import fetch_pkg::*;
(
    input  logic       br_taken,
    input  logic       jump,
    input  logic       trap,
    output logic [1:0] sel
);

    always_comb begin
        sel = SEL_SEQ;
        priority case (1'b1)
            trap:     sel = SEL_TRAP;
            jump:     sel = SEL_JMP;
            br_taken: sel = SEL_BR;
            default:  sel = SEL_SEQ;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC controller: PC register, imem req/ack handshake, IF/ID slot.
// Optional FETCH_DISCARD_CNT_EN adds a saturating discarded-fetch counter.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               INC      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             jump,
    input  logic             trap,
    input  logic [WIDTH-1:0] next_pc,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    output logic [WIDTH-1:0] fetch_instr
`ifdef FETCH_DISCARD_CNT_EN
    ,
    output logic [15:0]      discard_cnt
`endif
);

    fetch_state_t     state;
    logic [WIDTH-1:0] req_addr;
    logic             redirect;

    fetch_sel_prio u_sel (
        .br_taken (br_taken),
        .jump     (jump),
        .trap     (trap),
        .sel      (sel)
    );

    assign redirect  = trap | jump | br_taken;
    assign pc_inc    = pc + WIDTH'(INC);
    assign imem_req  = (state == REQ) || (state == DRAIN);
    assign imem_addr = req_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_instr <= '0;
        end else begin
            unique case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            pc       <= next_pc;
                            req_addr <= next_pc;
                        end else begin
                            fetch_valid <= 1'b1;
                            fetch_pc    <= req_addr;
                            fetch_instr <= imem_rdata;
                            state       <= HOLD;
                        end
                    end else if (redirect) begin
                        pc    <= next_pc;
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect || !stall) begin
                        fetch_valid <= 1'b0;
                        pc          <= next_pc;
                        req_addr    <= next_pc;
                        state       <= REQ;
                    end
                end
                DRAIN: begin
                    // Old request must complete; retarget to the newest PC.
                    if (redirect) pc <= next_pc;
                    if (imem_ack) begin
                        req_addr <= redirect ? next_pc : pc;
                        state    <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_DISCARD_CNT_EN
    logic discard;

    assign discard = (imem_ack && state == REQ && redirect)
                   || (imem_ack && state == DRAIN)
                   || (state == HOLD && redirect);

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (discard && discard_cnt != 16'hFFFF) begin
            discard_cnt <= discard_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, jump, trap, imem_ack;
    logic [31:0] next_pc, imem_rdata;
    logic [1:0]  sel;
    logic [31:0] pc_inc, pc, imem_addr, fetch_pc, fetch_instr;
    logic        imem_req, fetch_valid;
`ifdef FETCH_DISCARD_CNT_EN
    logic [15:0] discard_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // reference model: request in flight, response to drop, slot contents
    logic [31:0] m_pc, m_addr, m_fpc, m_finstr;
    logic        m_boot, m_busy, m_stale, m_valid;
    logic [15:0] m_cnt;
    logic [31:0] br_tgt, jmp_tgt, trap_vec;

    fetch_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .jump        (jump),
        .trap        (trap),
        .next_pc     (next_pc),
        .sel         (sel),
        .pc_inc      (pc_inc),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr)
`ifdef FETCH_DISCARD_CNT_EN
        ,
        .discard_cnt (discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_addr = 0; m_fpc = 0; m_finstr = 0;
        m_boot = 1; m_busy = 0; m_stale = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic bump();
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    // Called at a negedge: drive, check, advance one clock, update model.
    task automatic step(input logic r, s, b, j, t, a,
                        input logic [31:0] rd);
        logic [1:0]  es;
        logic [31:0] np;
        logic        redir;
        reset = r; stall = s; br_taken = b; jump = j; trap = t;
        imem_ack = a; imem_rdata = rd;
        es = t ? 2'd3 : j ? 2'd2 : b ? 2'd1 : 2'd0;
        case (es)
            2'd0:    np = m_pc + 32'd4;
            2'd1:    np = br_tgt;
            2'd2:    np = jmp_tgt;
            default: np = trap_vec;
        endcase
        next_pc = np;
        redir = b | j | t;
        #1;
        check("sel", 32'(sel), 32'(es));
        check("pc_inc", pc_inc, m_pc + 32'd4);
        check("pc", pc, m_pc);
        check("imem_req", 32'(imem_req), 32'(m_busy));
        check("imem_addr", imem_addr, m_addr);
        check("fetch_valid", 32'(fetch_valid), 32'(m_valid));
        check("fetch_pc", fetch_pc, m_fpc);
        check("fetch_instr", fetch_instr, m_finstr);
`ifdef FETCH_DISCARD_CNT_EN
        check("discard_cnt", 32'(discard_cnt), 32'(m_cnt));
`endif
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 0;
            m_busy = 1;
        end else if (m_busy) begin
            if (a) begin
                if (m_stale || redir) begin
                    if (redir) m_pc = np;
                    m_addr = m_pc;
                    m_stale = 0;
                    bump();
                end else begin
                    m_valid = 1; m_fpc = m_addr; m_finstr = rd;
                    m_busy = 0;
                end
            end else if (redir) begin
                m_pc = np;
                m_stale = 1;
            end
        end else if (redir || !s) begin
            if (redir) bump();
            m_valid = 0; m_pc = np; m_addr = np; m_busy = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1; stall = 0; br_taken = 0; jump = 0; trap = 0;
        imem_ack = 0; imem_rdata = 0; next_pc = 0;
        br_tgt = 32'h100; jmp_tgt = 32'h200; trap_vec = 32'h80;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        check("boot_req", 32'(imem_req), 0);
        step(0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 3; k++) begin
            check("seq_addr", imem_addr, 32'(4 * k));
            check("seq_req", 32'(imem_req), 1);
            step(0, 0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 1, 32'h13);
            check("seq_valid", 32'(fetch_valid), 1);
            check("seq_fpc", fetch_pc, 32'(4 * k));
            if (k < 2) step(0, 0, 0, 0, 0, 0, 0);
        end

        repeat (3) begin
            step(0, 1, 0, 0, 0, 0, 0);
            check("hold_fpc", fetch_pc, 32'h8);
            check("hold_instr", fetch_instr, 32'h13);
            check("hold_req", 32'(imem_req), 0);
            check("hold_pc", pc, 32'h8);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        check("rel_addr", imem_addr, 32'hC);

        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("drn_valid", 32'(fetch_valid), 0);
        check("drn_addr", imem_addr, 32'h100);

        step(0, 0, 1, 1, 1, 0, 0);
        check("prio_pc", pc, 32'h80);
        step(0, 0, 0, 0, 0, 1, 32'h1);
        check("prio_addr", imem_addr, 32'h80);

        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h55);
        check("rst_pc", pc, 32'h0);
        check("rst_valid", 32'(fetch_valid), 0);

`ifdef FETCH_DISCARD_CNT_EN
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 32'h13);
        step(0, 1, 0, 1, 0, 0, 0);
        check("cnt_three", 32'(discard_cnt), 3);
        repeat (65535) step(0, 0, 1, 0, 0, 1, 0);
        check("cnt_sat", 32'(discard_cnt), 32'hFFFF);
`endif

        repeat (3000) begin
            br_tgt   = $urandom & 32'hFFFF_FFFC;
            jmp_tgt  = $urandom & 32'hFFFF_FFFC;
            trap_vec = $urandom & 32'hFFFF_FFFC;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
